// File: rtl/sc_dec_pkg.sv
// -----------------------------------------------------------------------------
// sc_dec_pkg
// Shared types and helpers for the stochastic-computing bitstream decoder
// family.
//   sc_dec_state_t : decoder FSM state encoding (IDLE, WARM, ACC, DONE)
//   sc_dec_cnt_w() : ones-counter width for a window of 2^log_len bits.
//                    One extra bit holds the all-ones-window count (LEN).
// -----------------------------------------------------------------------------
package sc_dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } sc_dec_state_t;

    function automatic int sc_dec_cnt_w(input int log_len);
        return log_len + 1;
    endfunction

endpackage : sc_dec_pkg

// File: rtl/sc_ones_counter.sv
// -----------------------------------------------------------------------------
// sc_ones_counter
// Clearable, enabled ones accumulator over a 2^LOG_LEN-sample window.
// Each enabled cycle adds bit_in to the ones count and advances a LOG_LEN-bit
// cycle counter. 'last' flags that the sample taken on the current enabled
// edge is the final one of the window (cycle counter at all-ones).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : zero both counters (wins over en)
//   en         : accumulate bit_in and advance the cycle counter
//   bit_in     : stochastic stream bit
//   ones_cnt   : registered ones count, CW = LOG_LEN+1 bits
//   last       : current enabled sample is the last of the window
// -----------------------------------------------------------------------------
module sc_ones_counter
    import sc_dec_pkg::*;
#(
    parameter int LOG_LEN = 8,
    parameter int CW      = sc_dec_cnt_w(LOG_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [CW-1:0] ones_cnt,
    output logic          last
);

    logic [LOG_LEN-1:0] cyc_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_cnt <= '0;
            cyc_cnt  <= '0;
        end else if (clr) begin
            ones_cnt <= '0;
            cyc_cnt  <= '0;
        end else if (en) begin
            ones_cnt <= ones_cnt + CW'(bit_in);
            cyc_cnt  <= cyc_cnt + 1'b1;
        end
    end

    // The cycle counter wraps naturally; reaching all-ones means LEN-1 samples
    // are already in, so this edge takes the LEN-th.
    assign last = &cyc_cnt;

endmodule : sc_ones_counter

// File: rtl/sc_bitstream_decoder.sv
// -----------------------------------------------------------------------------
// sc_bitstream_decoder
// Counts the ones of a stochastic bitstream over a 2^LOG_LEN-cycle window and
// returns the saturated count through a valid/ready handshake.
// Optional feature macro: SC_DEC_WARMUP_EN -- inserts a WARM state that drops
// the first WARMUP stream bits after each start (upstream pipeline flops make
// the leading bits invalid).
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   start         : begin a window (honoured in IDLE or on the DONE handshake)
//   bit_in        : stochastic stream input
//   result        : ones count, clamped to all-ones when the window was all 1s
//   result_sat    : the clamp above happened
//   result_valid  : result available (held until result_ready)
//   result_ready  : consumer accepts result
//   busy          : decoder is not idle
// -----------------------------------------------------------------------------
module sc_bitstream_decoder
    import sc_dec_pkg::*;
#(
    parameter int LOG_LEN = 8,
    parameter int WARMUP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               bit_in,
    output logic [LOG_LEN-1:0] result,
    output logic               result_sat,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               busy
);

    localparam int CW = sc_dec_cnt_w(LOG_LEN);
    localparam logic [CW-1:0] LEN_V = {1'b1, {LOG_LEN{1'b0}}};

`ifdef SC_DEC_WARMUP_EN
    localparam sc_dec_state_t START_ST  = WARM;
    localparam logic [3:0]    WARM_LAST = 4'(WARMUP - 1);
    logic [3:0] warm_cnt;
`else
    localparam sc_dec_state_t START_ST  = ACC;
`endif

    sc_dec_state_t state;

    logic          launch;
    logic          acc_en;
    logic          last;
    logic [CW-1:0] ones_cnt;
    logic [CW-1:0] final_cnt;

    // A window launches from IDLE or straight out of the DONE handshake,
    // so back-to-back windows have no idle bubble.
    assign launch = start && ((state == IDLE) || ((state == DONE) && result_ready));
    assign acc_en = (state == ACC);

    // Count including the sample on this edge; used when the window closes.
    assign final_cnt = ones_cnt + CW'(bit_in);

    sc_ones_counter #(
        .LOG_LEN (LOG_LEN)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (launch),
        .en       (acc_en),
        .bit_in   (bit_in),
        .ones_cnt (ones_cnt),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            result       <= '0;
            result_sat   <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef SC_DEC_WARMUP_EN
            warm_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= START_ST;
                        busy  <= 1'b1;
`ifdef SC_DEC_WARMUP_EN
                        warm_cnt <= '0;
`endif
                    end
                end
`ifdef SC_DEC_WARMUP_EN
                WARM: begin
                    warm_cnt <= warm_cnt + 1'b1;
                    if (warm_cnt == WARM_LAST) state <= ACC;
                end
`endif
                ACC: begin
                    if (last) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        // Only a full window of ones reaches LEN; it does not
                        // fit in LOG_LEN bits, so clamp and flag it.
                        if (final_cnt == LEN_V) begin
                            result     <= '1;
                            result_sat <= 1'b1;
                        end else begin
                            result     <= final_cnt[LOG_LEN-1:0];
                            result_sat <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (start) begin
                            state <= START_ST;
`ifdef SC_DEC_WARMUP_EN
                            warm_cnt <= '0;
`endif
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule : sc_bitstream_decoder

// File: tb/tb_sc_bitstream_decoder.sv
// -----------------------------------------------------------------------------
// tb_sc_bitstream_decoder
// Directed bench for sc_bitstream_decoder (LOG_LEN=8). A window-level model
// (sample budget, running sum, pending result) is compared with the DUT on
// every falling edge, and hand-computed literals pin the key results.
// Build with SC_DEC_WARMUP_EN defined to exercise the warm-up variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sc_bitstream_decoder;

    localparam int LOG_LEN = 8;
    localparam int LEN     = 1 << LOG_LEN;
`ifdef SC_DEC_WARMUP_EN
    localparam int W = 1;
`else
    localparam int W = 0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               bit_in;
    logic [LOG_LEN-1:0] result;
    logic               result_sat;
    logic               result_valid;
    logic               result_ready;
    logic               busy;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    sc_bitstream_decoder #(.LOG_LEN(LOG_LEN), .WARMUP(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bit_in       (bit_in),
        .result       (result),
        .result_sat   (result_sat),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- window-level reference model ----------------
    bit m_active = 1'b0;
    bit m_valid  = 1'b0;
    bit m_sat    = 1'b0;
    int m_res    = 0;
    int m_skip   = 0;
    int m_left   = 0;
    int m_sum    = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_valid  <= 1'b0;
            m_res    <= 0;
            m_sat    <= 1'b0;
        end else if (m_active) begin
            if (m_skip > 0) begin
                m_skip <= m_skip - 1;
            end else begin
                m_sum  <= m_sum + int'(bit_in);
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_active <= 1'b0;
                    m_valid  <= 1'b1;
                    m_res    <= (m_sum + int'(bit_in) >= LEN) ? LEN - 1 : m_sum + int'(bit_in);
                    m_sat    <= (m_sum + int'(bit_in) == LEN);
                end
            end
        end else if (m_valid) begin
            if (result_ready) begin
                m_valid <= 1'b0;
                if (start) begin
                    m_active <= 1'b1; m_skip <= W; m_left <= LEN; m_sum <= 0;
                end
            end
        end else if (start) begin
            m_active <= 1'b1; m_skip <= W; m_left <= LEN; m_sum <= 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (armed) begin
            chk("busy", 32'(busy), 32'(m_active | m_valid));
            chk("result_valid", 32'(result_valid), 32'(m_valid));
            if (m_valid) begin
                chk("result", 32'(result), 32'(m_res));
                chk("result_sat", 32'(result_sat), 32'(m_sat));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Positioned at a falling edge: drive inputs, then advance one cycle.
    task automatic tick(input logic b, input logic s, input logic r);
        bit_in       = b;
        start        = s;
        result_ready = r;
        @(negedge clk);
    endtask

    function automatic logic pat_bit(input int pat, input int j);
        case (pat)
            0:       return 1'b1;              // all ones
            1:       return (j % 2) == 0;      // alternating
            2:       return (j % 4) == 0;      // one in four
            4:       return j < 50;            // first 50 ones
            default: return 1'b0;              // all zeros
        endcase
    endfunction

    // Feeds one window (warm-up bits driven as 1 so a failure to drop them
    // shows up). A stray start mid-window must be ignored.
    task automatic run_bits(input int pat);
        logic b;
        for (int i = 0; i < LEN + W; i++) begin
            b = (i < W) ? 1'b1 : pat_bit(pat, i - W);
            if (i == LEN + W - 1) chk("valid_before_last_sample", 32'(result_valid), 32'd0);
            tick(b, (i == 37), 1'b0);
        end
        chk("valid_at_latency", 32'(result_valid), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; bit_in = 1'b0; result_ready = 1'b0;
        @(negedge clk);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_valid", 32'(result_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sat", 32'(result_sat), 32'd0);
        rst_n = 1'b1;
        armed = 1'b1;
        tick(0, 0, 0);

        // All ones -> saturated
        tick(0, 1, 0);
        chk("busy_after_start", 32'(busy), 32'd1);
        run_bits(0);
        chk("ones_result", 32'(result), 32'd255);
        chk("ones_sat", 32'(result_sat), 32'd1);

        // Backpressure with a toggling stream
        for (int i = 0; i < 20; i++) begin
            tick(logic'(i % 2), 1'b0, 1'b0);
            chk("bp_hold_result", 32'(result), 32'd255);
            chk("bp_hold_valid", 32'(result_valid), 32'd1);
        end
        tick(0, 0, 1);
        chk("hs_valid_low", 32'(result_valid), 32'd0);
        chk("hs_busy_low", 32'(busy), 32'd0);

        // Alternating -> 128, then back-to-back 1-in-4 -> 64
        tick(0, 1, 0);
        run_bits(1);
        chk("alt_result", 32'(result), 32'd128);
        chk("alt_sat", 32'(result_sat), 32'd0);
        tick(0, 1, 1);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_valid_low", 32'(result_valid), 32'd0);
        run_bits(2);
        chk("quarter_result", 32'(result), 32'd64);
        chk("quarter_sat", 32'(result_sat), 32'd0);
        tick(0, 0, 1);

        // All zeros (with warm-up: first bit 1 and dropped)
        tick(0, 1, 0);
        run_bits(3);
        chk("zeros_result", 32'(result), 32'd0);
        tick(0, 0, 1);

        // Reset at sample 100 discards the partial count
        tick(0, 1, 0);
        for (int i = 0; i < W + 99; i++) tick(1, 0, 0);
        rst_n = 1'b0;
        tick(1, 0, 0);
        rst_n = 1'b1;
        chk("midrst_valid", 32'(result_valid), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        tick(0, 1, 0);
        run_bits(4);
        chk("fresh_result", 32'(result), 32'd50);
        tick(0, 0, 1);
        tick(0, 0, 0);
        chk("final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sc_bitstream_decoder
